video_timing_probe: RTL and testbench

- Measures an incoming pixel-domain video stream (HSync/VSync/DE) and reports its timing: totals, active sizes, sync widths and sync polarities.
- It is the receiving counterpart of our HS/VS/DE timing generators. It sits downstream of a generator or external source, ahead of OSD/scaler logic that needs the detected mode.
- Results are published only after the measured mode has been identical for STABLE_FRAMES consecutive frames.

---
 rtl/video_timing_pkg.sv | 29 ++
 rtl/sync_normalizer.sv | 32 +++
 rtl/video_timing_probe.sv | 188 ++++++++++++++++++
 tb/tb_video_timing_probe.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the video timing probe.
// Holds the measured-mode tuple and the frame FSM encoding.
package video_timing_pkg;

   localparam int HW_D = 12;
   localparam int VW_D = 11;

   typedef struct packed {
      logic [HW_D-1:0] h_total;
      logic [HW_D-1:0] h_active;
      logic [HW_D-1:0] h_sync;
      logic [VW_D-1:0] v_total;
      logic [VW_D-1:0] v_active;
      logic [VW_D-1:0] v_sync;
      logic            hs_pol;
      logic            vs_pol;
   } timing_t;

   typedef enum logic [1:0] {
      RESYNC,
      MEASURE,
      LOCKED
   } fsm_t;

   function automatic logic same_timing(input timing_t a, input timing_t b);
      return a == b;
   endfunction

endpackage

// File: rtl/sync_normalizer.sv
// Registers one sync input, learns its polarity from the blanking level
// seen during active video, and emits the active-level signal and its rise.
module sync_normalizer (
   input  logic clk_pix,
   input  logic reset,
   input  logic sync_in,
   input  logic latch,
   output logic pol,
   output logic act,
   output logic rise
);

   logic s_r;
   logic s_p;

   always_ff @(posedge clk_pix or posedge reset) begin
      if (reset) begin
         s_r <= 1'b0;
         s_p <= 1'b0;
         pol <= 1'b0;
      end else begin
         s_r <= sync_in;
         s_p <= s_r;
         if (latch) pol <= ~s_r;
      end
   end

   // Both samples use the same polarity so a polarity update never fakes an edge.
   assign act  = s_r ^ ~pol;
   assign rise = act & ~(s_p ^ ~pol);

endmodule

// File: rtl/video_timing_probe.sv
// Measures HS/VS/DE timing and publishes it once the mode is stable
// for STABLE_FRAMES consecutive frames.
module video_timing_probe
   import video_timing_pkg::*;
#(
   parameter int HW            = HW_D,
   parameter int VW            = VW_D,
   parameter int STABLE_FRAMES = 3
) (
   input  logic          clk_pix,
   input  logic          reset,
   input  logic          hs_in,
   input  logic          vs_in,
   input  logic          de_in,
   output logic [HW-1:0] h_total,
   output logic [HW-1:0] h_active,
   output logic [HW-1:0] h_sync,
   output logic [VW-1:0] v_total,
   output logic [VW-1:0] v_active,
   output logic [VW-1:0] v_sync,
   output logic          hs_pol,
   output logic          vs_pol,
   output logic          valid,
   output logic          changed,
   output logic          no_signal
);

   localparam logic [HW-1:0] HMAX = '1;
   localparam logic [VW-1:0] VMAX = '1;
   localparam logic [3:0]    SF   = 4'(STABLE_FRAMES);

   logic          de_r, de_seen, latch;
   logic          pol_h, pol_v, hs_act, vs_act;
   logic          line_start, vs_rise, vs_pend, frame_start;
   logic [HW-1:0] h_cnt, hsw, dec, lt, lt_ref, hact_cap;
   logic [VW-1:0] v_cnt, vact, vsw;
   logic          lt_set, f_bad, line_ok, line_bad, fr_bad, h_sat, dec_nz;
   logic [3:0]    stable_cnt;
   logic          eval_d;
   fsm_t          state;
   timing_t       meas, cand, pub;

   assign latch = de_r & (~de_seen | frame_start);

   sync_normalizer u_h (
      .clk_pix (clk_pix),
      .reset   (reset),
      .sync_in (hs_in),
      .latch   (latch),
      .pol     (pol_h),
      .act     (hs_act),
      .rise    (line_start)
   );

   sync_normalizer u_v (
      .clk_pix (clk_pix),
      .reset   (reset),
      .sync_in (vs_in),
      .latch   (latch),
      .pol     (pol_v),
      .act     (vs_act),
      .rise    (vs_rise)
   );

   // A vsync edge anywhere in a line takes effect at the next line start.
   assign frame_start = line_start & (vs_pend | vs_rise);
   assign lt          = h_cnt + HW'(1);
   assign dec_nz      = dec != '0;
   assign line_bad    = lt_set & (lt != lt_ref);
   assign h_sat       = (h_cnt == HMAX) & ~line_start;

   always_comb begin
      meas          = '0;
      meas.h_total  = lt;
      meas.h_active = dec_nz ? dec : hact_cap;
      meas.h_sync   = hsw;
      meas.v_total  = v_cnt;
      meas.v_active = vact + VW'(dec_nz);
      meas.v_sync   = vsw;
      meas.hs_pol   = pol_h;
      meas.vs_pol   = pol_v;
   end

   assign fr_bad = f_bad | line_bad | (v_cnt == VMAX) | (meas.v_active == '0);

   always_ff @(posedge clk_pix or posedge reset) begin
      if (reset) begin
         de_r       <= 1'b0;
         de_seen    <= 1'b0;
         vs_pend    <= 1'b0;
         h_cnt      <= '0;
         hsw        <= '0;
         dec        <= '0;
         lt_ref     <= '0;
         lt_set     <= 1'b0;
         hact_cap   <= '0;
         v_cnt      <= '0;
         vact       <= '0;
         vsw        <= '0;
         f_bad      <= 1'b0;
         line_ok    <= 1'b0;
         state      <= RESYNC;
         cand       <= '0;
         pub        <= '0;
         stable_cnt <= '0;
         eval_d     <= 1'b0;
         valid      <= 1'b0;
         changed    <= 1'b0;
         no_signal  <= 1'b0;
      end else begin
         de_r    <= de_in;
         eval_d  <= 1'b0;
         changed <= 1'b0;
         if (frame_start) de_seen <= de_r;
         else if (de_r)   de_seen <= 1'b1;
         if (line_start)   vs_pend <= 1'b0;
         else if (vs_rise) vs_pend <= 1'b1;
         if (line_start) begin
            h_cnt <= '0;
            hsw   <= HW'(1);
            dec   <= HW'(de_r);
         end else begin
            if (h_cnt != HMAX) h_cnt <= h_cnt + HW'(1);
            hsw <= hsw + HW'(hs_act);
            dec <= dec + HW'(de_r);
         end
         if (h_sat) begin
            no_signal  <= 1'b1;
            valid      <= 1'b0;
            line_ok    <= 1'b0;
            stable_cnt <= '0;
            state      <= RESYNC;
         end else if (line_start) begin
            no_signal <= 1'b0;
            line_ok   <= 1'b1;
            if (line_ok && frame_start) begin
               // The closing line belongs to the old frame; evaluate it first.
               if (state == RESYNC) begin
                  state <= MEASURE;
               end else if (fr_bad) begin
                  stable_cnt <= '0;
                  valid      <= 1'b0;
                  state      <= MEASURE;
               end else if (same_timing(meas, cand)) begin
                  if (stable_cnt != 4'hF) stable_cnt <= stable_cnt + 4'd1;
                  eval_d <= 1'b1;
               end else begin
                  cand       <= meas;
                  stable_cnt <= 4'd1;
                  valid      <= 1'b0;
                  eval_d     <= 1'b1;
                  state      <= MEASURE;
               end
               v_cnt    <= VW'(1);
               vsw      <= VW'(vs_act);
               vact     <= '0;
               hact_cap <= '0;
               f_bad    <= 1'b0;
               lt_set   <= 1'b0;
            end else if (line_ok) begin
               lt_set   <= 1'b1;
               lt_ref   <= lt;
               f_bad    <= f_bad | line_bad | (v_cnt == VMAX);
               hact_cap <= meas.h_active;
               vact     <= meas.v_active;
               if (v_cnt != VMAX) v_cnt <= v_cnt + VW'(1);
               vsw      <= vsw + VW'(vs_act);
            end
         end
         if (eval_d && stable_cnt >= SF) begin
            pub     <= cand;
            valid   <= 1'b1;
            changed <= ~same_timing(cand, pub);
            state   <= LOCKED;
         end
      end
   end

   assign h_total  = pub.h_total;
   assign h_active = pub.h_active;
   assign h_sync   = pub.h_sync;
   assign v_total  = pub.v_total;
   assign v_active = pub.v_active;
   assign v_sync   = pub.v_sync;
   assign hs_pol   = pub.hs_pol;
   assign vs_pol   = pub.vs_pol;

endmodule

// File: tb/tb_video_timing_probe.sv
// Directed bench for video_timing_probe using two scaled-down video modes,
// a mode switch, an over-long frame, signal loss and a mid-line reset.
module tb_video_timing_probe;

   typedef struct {
      int   ht;
      int   hsw;
      int   has;
      int   hae;
      int   vt;
      int   vsw;
      int   vas;
      int   vae;
      logic hp;
      logic vp;
   } mode_t;

   logic        clk_pix = 1'b0;
   logic        reset   = 1'b1;
   logic        hs_in   = 1'b1;
   logic        vs_in   = 1'b1;
   logic        de_in   = 1'b0;
   logic [11:0] h_total, h_active, h_sync;
   logic [10:0] v_total, v_active, v_sync;
   logic        hs_pol, vs_pol, valid, changed, no_signal;

   int n_chk = 0;
   int n_err = 0;
   int n_chg = 0;

   mode_t ma, mb;

   video_timing_probe dut (
      .clk_pix   (clk_pix),
      .reset     (reset),
      .hs_in     (hs_in),
      .vs_in     (vs_in),
      .de_in     (de_in),
      .h_total   (h_total),
      .h_active  (h_active),
      .h_sync    (h_sync),
      .v_total   (v_total),
      .v_active  (v_active),
      .v_sync    (v_sync),
      .hs_pol    (hs_pol),
      .vs_pol    (vs_pol),
      .valid     (valid),
      .changed   (changed),
      .no_signal (no_signal)
   );

   always #5 clk_pix = ~clk_pix;

   always @(negedge clk_pix) if (changed) n_chg++;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_pix);
      #1;
   endtask

   task automatic check_mode(input string tag, input mode_t m);
      check({tag, "_h_total"},  int'(h_total),  m.ht);
      check({tag, "_h_active"}, int'(h_active), m.hae - m.has);
      check({tag, "_h_sync"},   int'(h_sync),   m.hsw);
      check({tag, "_v_total"},  int'(v_total),  m.vt);
      check({tag, "_v_active"}, int'(v_active), m.vae - m.vas);
      check({tag, "_v_sync"},   int'(v_sync),   m.vsw);
      check({tag, "_hs_pol"},   int'(hs_pol),   int'(m.hp));
      check({tag, "_vs_pol"},   int'(vs_pol),   int'(m.vp));
   endtask

   task automatic check_zero();
      check("rst_h_total",  int'(h_total),  0);
      check("rst_h_active", int'(h_active), 0);
      check("rst_v_total",  int'(v_total),  0);
      check("rst_hs_pol",   int'(hs_pol),   0);
      check("rst_vs_pol",   int'(vs_pol),   0);
      check("rst_valid",    int'(valid),    0);
   endtask

   // Lines past the mode's total are blank lines with normal hsync.
   task automatic run_frame(input mode_t m, input int lines, input int rst_line);
      for (int l = 0; l < lines; l++) begin
         for (int c = 0; c < m.ht; c++) begin
            hs_in = (c < m.hsw) ? m.hp : ~m.hp;
            vs_in = (l < m.vsw) ? m.vp : ~m.vp;
            de_in = (l >= m.vas) && (l < m.vae) && (c >= m.has) && (c < m.hae);
            if (l == rst_line && c == m.ht / 2) begin
               reset = 1'b1;
               #1;
               check_zero();
            end
            step();
            reset = 1'b0;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

   initial begin
      ma = '{40, 6, 7, 39, 15, 2, 3, 13, 1'b0, 1'b0};
      mb = '{32, 4, 6, 30, 14, 3, 5, 13, 1'b1, 1'b1};

      repeat (3) step();
      check("reset_valid",     int'(valid),     0);
      check("reset_h_total",   int'(h_total),   0);
      check("reset_no_signal", int'(no_signal), 0);
      check("reset_changed",   int'(changed),   0);
      reset = 1'b0;

      repeat (4) run_frame(ma, ma.vt, -1);
      check("a_prelock", int'(valid), 0);
      run_frame(ma, ma.vt, -1);
      check("a_lock", int'(valid), 1);
      check_mode("a", ma);
      check("a_changed", n_chg, 1);

      run_frame(ma, ma.vt + 1, -1);
      run_frame(ma, ma.vt, -1);
      check("long_drop", int'(valid), 0);
      check("long_hold", int'(v_total), ma.vt);
      repeat (3) run_frame(ma, ma.vt, -1);
      check("long_relock", int'(valid), 1);
      check_mode("long", ma);
      check("long_changed", n_chg, 1);

      hs_in = ~ma.hp;
      vs_in = ~ma.vp;
      de_in = 1'b0;
      repeat (4000) step();
      check("nosig_early", int'(no_signal), 0);
      repeat (200) step();
      check("nosig_set",   int'(no_signal), 1);
      check("nosig_valid", int'(valid),     0);
      check("nosig_hold",  int'(h_total),   ma.ht);
      repeat (4) run_frame(ma, ma.vt, -1);
      check("nosig_clear",   int'(no_signal), 0);
      check("nosig_prelock", int'(valid),     0);
      run_frame(ma, ma.vt, -1);
      check("nosig_relock",  int'(valid), 1);
      check("nosig_changed", n_chg,       1);

      run_frame(ma, 5, -1);
      run_frame(mb, mb.vt, -1);
      check("switch_drop", int'(valid), 0);
      repeat (3) run_frame(mb, mb.vt, -1);
      check("switch_prelock", int'(valid), 0);
      run_frame(mb, mb.vt, -1);
      check("switch_lock", int'(valid), 1);
      check_mode("b", mb);
      check("switch_changed", n_chg, 2);

      run_frame(mb, mb.vt, 2);
      repeat (3) run_frame(mb, mb.vt, -1);
      check("rst_prelock", int'(valid), 0);
      run_frame(mb, mb.vt, -1);
      check("rst_relock", int'(valid), 1);
      check_mode("rst", mb);
      check("rst_changed", n_chg, 3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
